ofdm_symbol_framer: RTL

Cuts a continuous baseband sample stream into one AXI-Stream packet per OFDM symbol (cyclic prefix + FFT body) and issues that symbol's cyclic prefix length on a side AXI-Stream port. It sits directly upstream of the FFT block's cyclic-prefix removal stage: its data output feeds that stage's symbol input, and its `cp_len` output feeds that stage's CP-length input. CP lengths come from a programmable table that is cycled per symbol, which supports LTE/NR-style patterns (long CP on symbol 0, short CP afterwards).

---
 rtl/ofdm_framer_pkg.sv | 10 +
 rtl/ofdm_symbol_framer_cp_len_table.sv | 27 ++
 rtl/ofdm_symbol_framer.sv | 114 +++++++++++
 3 files changed

// File: rtl/ofdm_framer_pkg.sv
// ofdm_framer_pkg: shared state type and width helper for the OFDM symbol framer.
package ofdm_framer_pkg;

   typedef enum logic [1:0] {ST_LOAD, ST_WAIT_CP, ST_DATA} framer_state_t;

   function automatic int SYM_LEN_W(input int cp_w, input int fft_w);
      return ((cp_w > fft_w) ? cp_w : fft_w) + 1;
   endfunction

endpackage

// File: rtl/ofdm_symbol_framer_cp_len_table.sv
// cp_len_table: CP length register file, one write port, one combinational read port.
module cp_len_table
   import ofdm_framer_pkg::*;
#(
   parameter int CP_LEN_W = 12,
   parameter int TBL_AW   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr,
   input  logic [TBL_AW-1:0]   waddr,
   input  logic [CP_LEN_W-1:0] wdata,
   input  logic [TBL_AW-1:0]   raddr,
   output logic [CP_LEN_W-1:0] rdata
);

   logic [CP_LEN_W-1:0] mem [2**TBL_AW];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < 2**TBL_AW; i++) mem[i] <= '0;
      else if (wr)
         mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/ofdm_symbol_framer.sv
// ofdm_symbol_framer: cuts a sample stream into one packet per OFDM symbol (CP + FFT body)
// and issues each symbol's CP length on a side stream.
module ofdm_symbol_framer
   import ofdm_framer_pkg::*;
#(
   parameter int CP_LEN_W = 12,
   parameter int FFT_W    = 13,
   parameter int DATA_W   = 32,
   parameter int TBL_AW   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [FFT_W-1:0]    cfg_fft_size,
   input  logic [TBL_AW:0]     cfg_tbl_len,
   input  logic                cfg_wr,
   input  logic [TBL_AW-1:0]   cfg_addr,
   input  logic [CP_LEN_W-1:0] cfg_data,
   input  logic                resync,
   input  logic [DATA_W-1:0]   i_tdata,
   input  logic                i_tvalid,
   output logic                i_tready,
   output logic [DATA_W-1:0]   o_tdata,
   output logic                o_tlast,
   output logic                o_tvalid,
   input  logic                o_tready,
   output logic [CP_LEN_W-1:0] cp_len_tdata,
   output logic                cp_len_tvalid,
   input  logic                cp_len_tready,
   output logic [TBL_AW-1:0]   sym_idx
);

   localparam int SLW = SYM_LEN_W(CP_LEN_W, FFT_W);

   framer_state_t       state;
   logic [TBL_AW-1:0]   idx;
   logic [SLW-1:0]      count, sym_len;
   logic [CP_LEN_W-1:0] cp, tbl_rd;
   logic [TBL_AW:0]     tbl_len, idx_inc;
   logic [FFT_W-1:0]    fft_eff;
   logic                resync_q, in_data, beat, last, cp_busy;

   cp_len_table #(.CP_LEN_W(CP_LEN_W), .TBL_AW(TBL_AW)) u_tbl (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (cfg_wr),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (idx),
      .rdata (tbl_rd)
   );

   always_comb begin
      in_data  = state == ST_DATA;
      i_tready = in_data & o_tready;
      o_tvalid = in_data & i_tvalid;
      o_tdata  = in_data ? i_tdata : '0;
      last     = in_data && count == sym_len - SLW'(1);
      o_tlast  = last;
      beat     = o_tvalid & o_tready;
      fft_eff  = cfg_fft_size == '0 ? FFT_W'(1) : cfg_fft_size;
      idx_inc  = {1'b0, idx} + (TBL_AW+1)'(1);
      cp_busy  = cp_len_tvalid & ~cp_len_tready;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= ST_LOAD;
         idx           <= '0;
         count         <= '0;
         sym_len       <= '0;
         cp            <= '0;
         tbl_len       <= '0;
         resync_q      <= 1'b0;
         cp_len_tvalid <= 1'b0;
         cp_len_tdata  <= '0;
         sym_idx       <= '0;
      end else begin
         if (cp_len_tvalid && cp_len_tready) cp_len_tvalid <= 1'b0;
         if (resync) resync_q <= 1'b1;
         case (state)
            ST_LOAD: begin
               cp       <= tbl_rd;
               sym_len  <= SLW'(tbl_rd) + SLW'(fft_eff);
               tbl_len  <= cfg_tbl_len == '0 ? (TBL_AW+1)'(1) : cfg_tbl_len;
               count    <= '0;
               sym_idx  <= idx;
               resync_q <= resync;
               if (cp_busy)
                  state <= ST_WAIT_CP;
               else begin
                  cp_len_tdata  <= tbl_rd;
                  cp_len_tvalid <= 1'b1;
                  state         <= ST_DATA;
               end
            end
            ST_WAIT_CP:
               if (!cp_busy) begin
                  cp_len_tdata  <= cp;
                  cp_len_tvalid <= 1'b1;
                  state         <= ST_DATA;
               end
            default:
               if (beat) begin
                  count <= count + SLW'(1);
                  if (last) begin
                     // a pending resync restarts the CP pattern at entry 0
                     idx   <= (resync_q || resync || idx_inc >= tbl_len) ? '0 : idx_inc[TBL_AW-1:0];
                     state <= ST_LOAD;
                  end
               end
         endcase
      end

endmodule
